// File: rtl/glip_uart_defs.sv
// Shared UART constants: credit-related defaults and a constant-foldable clog2.
package glip_uart_defs;

  localparam int AF_OFFSET_DEFAULT = 6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/glip_uart_sdp_ram.sv
// Simple dual-port RAM with registered read, coded for block-RAM inference.
module glip_uart_sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic             clk_io,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_io) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write on address collision; the caller bypasses that case.
  always_ff @(posedge clk_io) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/glip_uart_rx_buffer.sv
// FWFT ingress byte buffer: inferred RAM plus one prefetch register, with
// almost-full backpressure, fill level and sticky overflow.
module glip_uart_rx_buffer
  import glip_uart_defs::*;
#(
  parameter int WIDTH              = 8,
  parameter int DEPTH              = 4096,
  parameter int ALMOST_FULL_OFFSET = AF_OFFSET_DEFAULT
) (
  input  logic                  clk_io,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  in_almost_full,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             overflow_q, overflow_d;
  logic             byp_sel_q, byp_sel_d;
  logic [WIDTH-1:0] byp_q;

  logic             wr, pop, ram_empty, ram_we, ram_adv, to_out;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] ram_rdata, ram_head;

  assign in_ready       = (count_q != CW'(DEPTH));
  assign in_almost_full = (count_q >= CW'(DEPTH - ALMOST_FULL_OFFSET));
  assign out_valid      = (count_q != '0);
  assign out_data       = out_q;
  assign count          = count_q;
  assign overflow       = overflow_q;

  assign wr        = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // The output register is always filled first, so equal pointers mean RAM is empty.
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign to_out    = wr & (~out_valid | (pop & ram_empty));
  assign ram_we    = wr & ~to_out;
  assign ram_adv   = pop & ~ram_empty;
  assign raddr     = ram_adv ? rd_ptr_q + AW'(1) : rd_ptr_q;
  // A RAM head written on the same edge it was read shows up via the bypass copy.
  assign ram_head  = byp_sel_q ? byp_q : ram_rdata;

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_d      = out_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    byp_sel_d  = ram_we & (wr_ptr_q == raddr);
    if (wr & ~pop)      count_d = count_q + CW'(1);
    else if (~wr & pop) count_d = count_q - CW'(1);
    if (ram_we)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (ram_adv) rd_ptr_d = rd_ptr_q + AW'(1);
    if (to_out)       out_d = in_data;
    else if (ram_adv) out_d = ram_head;
  end

  always_ff @(posedge clk_io) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      byp_sel_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      byp_sel_q  <= byp_sel_d;
    end
  end

  always_ff @(posedge clk_io) begin
    out_q <= out_d;
    byp_q <= in_data;
  end

  glip_uart_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_io (clk_io),
    .we     (ram_we),
    .waddr  (wr_ptr_q),
    .wdata  (in_data),
    .raddr  (raddr),
    .rdata  (ram_rdata)
  );

endmodule

// File: tb/tb_glip_uart_rx_buffer.sv
// Scoreboard bench for glip_uart_rx_buffer at DEPTH=16, ALMOST_FULL_OFFSET=6.
module tb_glip_uart_rx_buffer;

  localparam int DEPTH = 16;
  localparam int AFO   = 6;

  logic       clk_io = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_almost_full;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  int         n_acc = 0;

  glip_uart_rx_buffer #(
    .WIDTH              (8),
    .DEPTH              (DEPTH),
    .ALMOST_FULL_OFFSET (AFO)
  ) dut (
    .clk_io         (clk_io),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_almost_full (in_almost_full),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 clk_io = ~clk_io;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: drive, check against model at negedge, update model, cross posedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    logic do_wr, do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk_io);
    chk("count", 32'(count), 32'(m_cnt));
    chk("in_ready", 32'(in_ready), 32'(m_cnt != DEPTH));
    chk("almost_full", 32'(in_almost_full), 32'(m_cnt >= DEPTH - AFO));
    chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_cnt != 0 && sb_q.size() > 0) chk("out_data", 32'(out_data), 32'(sb_q[0]));
    do_pop = (m_cnt != 0) && r;
    do_wr  = v && (m_cnt != DEPTH);
    if (v && m_cnt == DEPTH) m_ovf = 1'b1;
    if (do_pop) void'(sb_q.pop_front());
    if (do_wr) begin
      sb_q.push_back(d);
      n_acc++;
    end
    if (do_wr && !do_pop) m_cnt++;
    else if (!do_wr && do_pop) m_cnt--;
    @(posedge clk_io);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk_io);
    #1;
    rst   = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    sb_q.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk_io);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_almost_full", 32'(in_almost_full), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // empty bypass
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("bypass_data", 32'(out_data), 32'hA5);
    chk("bypass_count", 32'(count), 1);
    drain();

    // fill to full, overflow, drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    chk("full_overflow", 32'(overflow), 1);
    chk("full_count", 32'(count), 16);
    drain();
    chk("full_drained", 32'(sb_q.size()), 0);

    // streaming 100 bytes
    do_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, 8'(i + 1), 1'b1);
    chk("stream_count", 32'(count), 1);
    drain();

    // write+pop at count=1, then at count=16
    do_reset();
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b1);
    chk("wp1_count", 32'(count), 1);
    chk("wp1_data", 32'(out_data), 32'h22);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    chk("wp16_count", 32'(count), 15);
    chk("wp16_overflow", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

    // reset mid-operation at count=7 with overflow set
    chk("mid_count", 32'(count), 7);
    do_reset();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("mid_after_data", 32'(sb_q.size()), 0);
    drain();

    // random backpressure
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 2000; i++) begin
      logic v, r;
      v = ($urandom_range(99, 0) < 95);
      r = ($urandom_range(99, 0) < (((i / 100) % 2 == 0) ? 97 : 80));
      cycle(v, 8'($urandom), r);
    end
    chk("wraps_over_100", 32'((n_acc / DEPTH) > 100), 1);
    drain();
    chk("random_drained", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glip_uart_rx_buffer.md
Name: glip_uart_rx_buffer

Overview:
- Single-clock, first-word-fall-through (FWFT) byte buffer in the clk_io domain, on the UART ingress path.
- Sits between the UART control block's ingress output and the clock-domain-crossing FIFO towards clk_logic.
- Vendor-independent inferred-RAM replacement for the large primitive-based ingress buffer.
- Provides the almost-full backpressure the control block uses for credit flow control, plus fill level and a sticky overflow flag.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 4096, total capacity in entries; power of two, >= 4.
- ALMOST_FULL_OFFSET, 6, almost_full asserts when count >= DEPTH - ALMOST_FULL_OFFSET; range 1..DEPTH-1.

Ports:
- clk_io  in  1  I/O clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset; the instantiating level drives it from its communication reset.
- in_data  in  WIDTH  write data.
- in_valid  in  1  write request.
- in_ready  out  1  not full; a write is accepted only when in_valid & in_ready.
- in_almost_full  out  1  almost-full threshold reached.
- out_data  out  WIDTH  head entry; valid whenever out_valid=1.
- out_valid  out  1  buffer non-empty (FWFT).
- out_ready  in  1  consumer accepts head; pop on out_valid & out_ready.
- count  out  $clog2(DEPTH)+1  number of stored entries, output stage included.
- overflow  out  1  sticky: write attempted while full.

Behaviour:
- Reset values:
  - count=0, out_valid=0, in_ready=1, in_almost_full=0, overflow=0.
  - out_data is don't-care.
  - Pointers are zeroed; RAM contents are not cleared.
- Reset mid-operation discards all contents. On the first cycle after reset the block behaves as empty.
- Storage:
  - Inferred simple-dual-port RAM with 1-cycle registered read, plus one output (prefetch) register.
  - Total capacity is exactly DEPTH, as counted by count.
- Status outputs:
  - in_ready = (count != DEPTH).
  - in_almost_full = (count >= DEPTH - ALMOST_FULL_OFFSET).
  - Both derive combinationally from the count register only; no dependency on in_valid or out_ready.
- Write accepted (in_valid & in_ready) -> entry stored at the tail.
- Write while full (in_valid & ~in_ready):
  - Data is dropped, overflow <= 1, count unchanged.
  - overflow clears only on rst.
- A simultaneous pop while full does not make the write acceptable; in_ready reflects the pre-edge count.
- count update per edge: +1 on write only, -1 on pop only, unchanged on both or neither.
- Latency and bypass:
  - A write accepted at edge k into an empty buffer (count=0) bypasses RAM.
  - That entry is loaded into the output register, giving out_valid=1 and out_data=entry after edge k.
  - When the output register holds data and RAM is non-empty, a pop at edge k refills the output register from RAM with no bubble: out_valid stays 1 and the next entry is presented after edge k.
  - This requires a look-ahead RAM read address (read pointer + 1 on pop).
- Write to a buffer holding exactly one entry, simultaneous with its pop: the new entry goes straight to the output register; out_valid stays 1.
- Throughput: 1 write and 1 pop per cycle sustained, at any fill level.
- Ordering: strict FIFO; no reordering or duplication.
- out_data is held stable while out_valid & ~out_ready.
- Pointers: $clog2(DEPTH) bits each, wrapping naturally modulo DEPTH.

Decomposition:
- Shared package/header glip_uart_defs: the clog2 constant function and the default ALMOST_FULL_OFFSET value (6), shared with the control block's credit constants.
- One sub-module: glip_uart_sdp_ram, a WIDTH x DEPTH simple dual-port RAM (write port: we/waddr/wdata; registered read port: raddr/rdata), written so synthesis infers block RAM.
- FWFT control, count and flags live in glip_uart_rx_buffer.

Test Plan:
Bench uses DEPTH=16, ALMOST_FULL_OFFSET=6 unless stated.
- Empty bypass: write 0xA5 at edge k, out_ready=0 -> out_valid=1 and out_data=0xA5 after edge k; count=1.
- Fill to full: 16 writes of 0x00..0x0F, no pops:
  - in_almost_full rises once count=10.
  - in_ready=0 once count=16.
  - A 17th write of 0xFF -> overflow=1, count stays 16.
  - Draining then yields 0x00..0x0F in order; 0xFF never appears.
- Streaming: in_valid=1 and out_ready=1 every cycle for 100 bytes (incrementing data) -> no bubbles after the first byte, output matches input order, count stays at 1.
- Simultaneous write+pop:
  - At count=1 -> count stays 1 and the new byte appears next cycle.
  - At count=16 -> write rejected, overflow=1, count=15.
- Reset mid-operation: count=7, assert rst for 1 cycle -> count=0, out_valid=0, overflow=0, in_ready=1. A subsequent write of 0x3C is the next byte output.
- Random backpressure: 2000 random in_valid/out_ready cycles against a scoreboard model -> no data mismatch. count and in_almost_full match the model every cycle, and pointer wrap-around is exercised more than 100 times.
